mem_ring_arbiter: RTL and testbench
===================================

MEM_RING_ARBITER -- requirements
Module: mem_ring_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the data word width.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning the memory entry count; it must be a power of 2, and AW = log2(DEPTH) = 4.
REQ-003 The block SHALL have parameter NUM_REQ, default 2, meaning the number of write requesters (2..4).
REQ-004 clk  input  1  clock; all logic is rising-edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  NUM_REQ  per-requester write request.
REQ-007 req_data  input  NUM_REQ*DATA_W  per-requester write data; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 req_ready  output  NUM_REQ  per-requester grant; a write transfers when valid and ready are both high.
REQ-009 rd_valid, rd_data  output  1, DATA_W  head entry is available, and its value.
REQ-010 rd_ready  input  1  consumer accepts the head entry.
REQ-011 flush  input  1  synchronous clear of buffer state.
REQ-012 mem_we, mem_waddr, mem_wdata  output  1, AW, DATA_W  write port to the external register array.
REQ-013 mem_raddr  output  AW, and mem_rdata  input  DATA_W  asynchronous read port of the array.
REQ-014 count  output  AW+1, full  output  1, empty  output  1  occupancy status.
REQ-015 grant_id  output  2  index of the last granted requester; wr_total  output  8  count of accepted writes.

Function
REQ-016 req_ready SHALL be combinational and one-hot-or-zero.
- Zero when full=1 or flush=1.
- Otherwise it selects the first requester with req_valid=1, searching round-robin from pointer rr_ptr.
REQ-017 After a grant to requester i, rr_ptr SHALL become (i+1) mod NUM_REQ on the next edge; with no grant, rr_ptr holds.
REQ-018 On a write transfer, the block SHALL drive the following in the same cycle:
- mem_we=1;
- mem_waddr=wr_ptr;
- mem_wdata = data of the granted requester.
wr_ptr SHALL then increment mod DEPTH (15 wraps to 0).
REQ-019 rd_valid SHALL equal !empty and SHALL be zero while flush=1.
- mem_raddr = rd_ptr.
- rd_data = mem_rdata, combinational.
REQ-020 On a pop (rd_valid & rd_ready), rd_ptr SHALL increment mod DEPTH.
REQ-021 count SHALL update as follows:
- +1 on a push only;
- -1 on a pop only;
- unchanged on a simultaneous push and pop.
REQ-022 full SHALL equal (count==DEPTH), and empty SHALL equal (count==0).
REQ-023 While full, no write is accepted, even if a pop occurs in the same cycle; the freed slot becomes grantable the next cycle.
REQ-024 While empty, a push SHALL NOT bypass to rd_valid; the data becomes readable one cycle after the push.
REQ-025 flush=1 SHALL clear wr_ptr, rd_ptr, count and rr_ptr at the next edge.
- No push and no pop occur in the flush cycle.
- grant_id and wr_total hold.
REQ-026 grant_id SHALL register the index of each granted requester; wr_total SHALL increment by 1 per accepted write, wrapping 255 to 0.
REQ-027 Producers SHALL hold req_valid and req_data stable until the transfer completes; the block does not store ungranted data.

Reset
REQ-028 On rst=1 the following registers SHALL be cleared immediately, regardless of clk: wr_ptr, rd_ptr, count, rr_ptr, grant_id and wr_total.
REQ-029 During reset the outputs SHALL be:
- req_ready=0, mem_we=0, rd_valid=0;
- empty=1, full=0, count=0.
REQ-030 Reset asserted mid-operation SHALL discard all buffered entries; the first grant after deassertion goes to requester 0.

Structure
REQ-031 A shared package SHALL hold the defaults DATA_W, DEPTH and NUM_REQ, the AW derivation, and the grant_id width.
REQ-032 The round-robin search SHALL be a sub-module rr_arbiter, with inputs req and rr_ptr and outputs onehot grant and index.
REQ-033 The register array remains external; this block holds only pointers, counters and arbitration state.

Verification
REQ-034 Single-requester wrap: requester 0 writes 0x00..0x13 (20 words) with rd_ready=1 throughout → rd_data sequence matches; mem_waddr wraps 15→0; count never exceeds 2.
REQ-035 Contention: both req_valid held high for 8 cycles with rd_ready=1 → grants alternate 0,1,0,1…; grant_id toggles; wr_total=8.
REQ-036 Fill: 16 writes with rd_ready=0 → count=16, full=1, req_ready=0.
- In the next cycle, rd_ready=1 with req_valid=1 → a pop occurs, no push, count=15.
- In the following cycle, one push occurs.
REQ-037 Empty push: with empty=1, push 0xA5 → rd_valid=0 that cycle, rd_valid=1 and rd_data=0xA5 the next cycle.
REQ-038 Flush: with count=5, pulse flush → count=0, empty=1, wr_total unchanged, next write lands at address 0.
REQ-039 Async reset with count=7, asserted between edges → count=0 and req_ready=0 immediately; after release, the first grant goes to requester 0.

Source files
------------

// File: rtl/mem_ring_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_ring_arbiter_pkg                                                 |
// | Shared defaults and derived widths for the ring-buffer arbiter.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mem_ring_arbiter_pkg;
  localparam int c_data_w  = 8;
  localparam int c_depth   = 16;
  localparam int c_num_req = 2;
  localparam int c_aw      = $clog2(c_depth);
  localparam int c_gid_w   = 2;
  localparam int c_total_w = 8;
endpackage
`default_nettype wire

// File: rtl/mem_ring_arbiter_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter                                                           |
// | Round-robin search for the first active request from rr_ptr.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arbiter
  import mem_ring_arbiter_pkg::*;
#(
  parameter int N = c_num_req
) (
  input  logic [N-1:0]       req,
  input  logic [c_gid_w-1:0] rr_ptr,
  output logic [N-1:0]       grant,
  output logic [c_gid_w-1:0] index
);

  logic [3:0] w_req_ext;
  logic [3:0] w_grant_ext;
  logic [2:0] w_cand;
  logic       w_found;

  // Requests are widened to four lanes so the candidate index never overruns.
  always_comb begin
    w_req_ext          = '0;
    w_req_ext[N-1:0]   = req;
    w_grant_ext        = '0;
    w_cand             = '0;
    w_found            = 1'b0;
    index              = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = {1'b0, rr_ptr} + 3'(k);
      if (w_cand >= 3'(N)) begin
        w_cand = w_cand - 3'(N);
      end
      if (!w_found && w_req_ext[w_cand[1:0]]) begin
        w_found                    = 1'b1;
        w_grant_ext[w_cand[1:0]]   = 1'b1;
        index                      = w_cand[c_gid_w-1:0];
      end
    end
    grant = w_grant_ext[N-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/mem_ring_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_ring_arbiter                                                     |
// | Multi-requester write arbiter and FIFO pointer control for an        |
// | external register array.                                             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_ring_arbiter
  import mem_ring_arbiter_pkg::*;
#(
  parameter int DATA_W  = c_data_w,
  parameter int DEPTH   = c_depth,
  parameter int NUM_REQ = c_num_req
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        rd_valid,
  output logic [DATA_W-1:0]           rd_data,
  input  logic                        rd_ready,
  input  logic                        flush,
  output logic                        mem_we,
  output logic [$clog2(DEPTH)-1:0]    mem_waddr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic [$clog2(DEPTH)-1:0]    mem_raddr,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        full,
  output logic                        empty,
  output logic [c_gid_w-1:0]          grant_id,
  output logic [c_total_w-1:0]        wr_total
);

  localparam int c_addr_w = $clog2(DEPTH);

  logic [c_addr_w-1:0]  r_wr_ptr;
  logic [c_addr_w-1:0]  r_rd_ptr;
  logic [c_addr_w:0]    r_count;
  logic [c_gid_w-1:0]   r_rr_ptr;
  logic [c_gid_w-1:0]   r_grant_id;
  logic [c_total_w-1:0] r_wr_total;

  logic [NUM_REQ-1:0]   w_grant;
  logic [c_gid_w-1:0]   w_gnt_idx;
  logic [2:0]           w_rr_next;
  logic [DATA_W-1:0]    w_wdata;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;

  rr_arbiter #(
    .N      (NUM_REQ)
  ) u_rr (
    .req    (req_valid),
    .rr_ptr (r_rr_ptr),
    .grant  (w_grant),
    .index  (w_gnt_idx)
  );

  assign w_full  = (r_count == (c_addr_w+1)'(DEPTH));
  assign w_empty = (r_count == '0);

  // A pop while full does not free the slot for a grant until the next cycle.
  assign req_ready = (rst || w_full || flush) ? '0 : w_grant;
  assign w_push    = |req_ready;
  assign rd_valid  = !w_empty && !flush && !rst;
  assign w_pop     = rd_valid && rd_ready;

  always_comb begin
    w_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_wdata = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_rr_next = {1'b0, w_gnt_idx} + 3'd1;
    if (w_rr_next == 3'(NUM_REQ)) begin
      w_rr_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_wr_total <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + 1'b1;
        r_rr_ptr   <= w_rr_next[c_gid_w-1:0];
        r_grant_id <= w_gnt_idx;
        r_wr_total <= r_wr_total + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign mem_we    = w_push;
  assign mem_waddr = r_wr_ptr;
  assign mem_wdata = w_wdata;
  assign mem_raddr = r_rd_ptr;
  assign rd_data   = mem_rdata;
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;
  assign grant_id  = r_grant_id;
  assign wr_total  = r_wr_total;

endmodule
`default_nettype wire

// File: tb/tb_mem_ring_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_ring_arbiter                                                  |
// | Directed and random checks against a queue-based reference model.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mem_ring_arbiter;
  localparam int NR = 2;
  localparam int DW = 8;
  localparam int DP = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]   req_ready;
  logic            rd_valid;
  logic [DW-1:0]   rd_data;
  logic            rd_ready = 1'b0;
  logic            flush = 1'b0;
  logic            mem_we;
  logic [3:0]      mem_waddr;
  logic [DW-1:0]   mem_wdata;
  logic [3:0]      mem_raddr;
  logic [DW-1:0]   mem_rdata;
  logic [4:0]      count;
  logic            full;
  logic            empty;
  logic [1:0]      grant_id;
  logic [7:0]      wr_total;

  logic [DW-1:0]   mem [DP];

  int errors = 0;
  int checks = 0;

  logic [7:0] q[$];
  int m_rr, m_wp, m_gid, m_tot, m_last;
  int maxcnt;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;
  assign mem_rdata = mem[mem_raddr];

  mem_ring_arbiter #(.DATA_W(DW), .DEPTH(DP), .NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_ready(rd_ready), .flush(flush), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .count(count), .full(full), .empty(empty),
    .grant_id(grant_id), .wr_total(wr_total)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rr = 0; m_wp = 0; m_gid = 0; m_tot = 0; m_last = -1;
  endtask

  // One clock cycle: check combinational outputs mid-cycle, advance the model
  // at the edge, then check registered status just after it.
  task automatic cycle();
    int g, c;
    bit mrv;
    logic [7:0] d;
    #2;
    g = -1;
    if (!flush && q.size() < DP) begin
      for (int k = 0; k < NR; k++) begin
        c = (m_rr + k) % NR;
        if (req_valid[c]) begin g = c; break; end
      end
    end
    d = (g >= 0) ? req_data[g*DW +: DW] : 8'h00;
    chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("mem_we", 32'(mem_we), 32'(g >= 0));
    if (g >= 0) begin
      chk("mem_waddr", 32'(mem_waddr), 32'(m_wp));
      chk("mem_wdata", 32'(mem_wdata), 32'(d));
    end
    mrv = (q.size() != 0) && !flush;
    chk("rd_valid", 32'(rd_valid), 32'(mrv));
    if (mrv) chk("rd_data", 32'(rd_data), 32'(q[0]));
    @(posedge clk);
    if (flush) begin
      q.delete(); m_rr = 0; m_wp = 0;
    end else begin
      if (mrv && rd_ready) void'(q.pop_front());
      if (g >= 0) begin
        q.push_back(d);
        m_wp = (m_wp + 1) % DP;
        m_rr = (g + 1) % NR;
        m_gid = g;
        m_tot = (m_tot + 1) % 256;
      end
    end
    m_last = g;
    #1;
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DP));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("wr_total", 32'(wr_total), 32'(m_tot));
    if (q.size() > maxcnt) maxcnt = q.size();
  endtask

  task automatic drain();
    req_valid = '0; rd_ready = 1'b1; flush = 1'b0;
    for (int i = 0; i < 20 && q.size() != 0; i++) cycle();
  endtask

  initial begin
    int tot0;
    model_reset();
    req_valid = 2'b11;
    #3;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;

    // Single requester streaming through the pointer wrap.
    maxcnt = 0;
    rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      req_valid = 2'b01;
      req_data[7:0] = 8'(i);
      cycle();
    end
    req_valid = '0;
    cycle(); cycle();
    chk("wrap_maxcount_le2", 32'(maxcnt <= 2), 1);

    // Contention from a clean reset: strict alternation.
    rst = 1'b1; #1; rst = 1'b0; model_reset();
    rd_ready = 1'b1;
    req_valid = 2'b11;
    req_data = {8'h80, 8'h00};
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("alt_grant", 32'(grant_id), 32'(i % 2));
      if (m_last >= 0) req_data[m_last*DW +: DW] = req_data[m_last*DW +: DW] + 8'h01;
    end
    chk("contention_total", 32'(wr_total), 8);
    drain();

    // Fill to full, then pop with requests pending.
    rd_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      req_valid = 2'b01; req_data[7:0] = 8'h40 + 8'(i);
      cycle();
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 16);
    #2; chk("fill_ready", 32'(req_ready), 0); #3; @(negedge clk); @(posedge clk); #1;
    rd_ready = 1'b1; req_valid = 2'b01; req_data[7:0] = 8'hEE;
    cycle();
    chk("full_pop_count", 32'(count), 15);
    rd_ready = 1'b0;
    cycle();
    chk("refill_count", 32'(count), 16);
    drain();

    // Push into empty buffer: no bypass.
    rd_ready = 1'b0; req_valid = 2'b01; req_data[7:0] = 8'hA5;
    cycle();
    req_valid = '0;
    #2;
    chk("empty_push_rv", 32'(rd_valid), 1);
    chk("empty_push_data", 32'(rd_data), 32'h00A5);
    #3; @(posedge clk); #1;
    drain();

    // Flush with five entries.
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 2'b10; req_data[15:8] = 8'h10 + 8'(i);
      cycle();
    end
    chk("pre_flush_count", 32'(count), 5);
    tot0 = m_tot;
    flush = 1'b1; req_valid = 2'b11;
    cycle();
    flush = 1'b0;
    chk("flush_count", 32'(count), 0);
    chk("flush_total", 32'(wr_total), 32'(tot0));
    req_valid = 2'b01; req_data[7:0] = 8'h5A;
    #2; chk("post_flush_addr", 32'(mem_waddr), 0); #1;
    @(posedge clk); #1;
    q.push_back(8'h5A); m_wp = 1; m_rr = 1; m_gid = 0; m_tot = (m_tot + 1) % 256;
    drain();

    // Random traffic with producers holding data until granted.
    req_valid = '0;
    for (int n = 0; n < 400; n++) begin
      for (int r = 0; r < NR; r++) begin
        if (!req_valid[r] || m_last == r) begin
          req_valid[r] = 1'($urandom_range(0, 1));
          req_data[r*DW +: DW] = 8'($urandom);
        end
      end
      rd_ready = (n < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 29) == 0);
      cycle();
    end
    flush = 1'b0;
    drain();

    // Asynchronous reset between edges with seven entries held.
    rd_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      req_valid = 2'b01; req_data[7:0] = 8'h70 + 8'(i);
      cycle();
    end
    chk("pre_rst_count", 32'(count), 7);
    req_valid = 2'b11;
    rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_ready", 32'(req_ready), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_rd_valid", 32'(rd_valid), 0);
    #1;
    rst = 1'b0;
    model_reset();
    cycle();
    chk("arst_first_grant", 32'(m_last), 0);
    chk("arst_grant_id", 32'(grant_id), 0);
    req_valid = '0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
